sp_fwd_unit: RTL and testbench

Parametrised stack-pointer forwarding and tracking unit for the five-stage pipeline. It holds the architectural SP, which is updated by push, pop and load commits from writeback. On request it returns the newest SP value, taken either from the youngest valid in-flight pipeline stage or from the architectural register. It also flags stack overflow and underflow as sticky status bits.

---
 rtl/sp_fwd_if.sv | 42 ++++
 rtl/sp_fwd_unit.sv | 116 +++++++++++
 tb/tb_sp_fwd_unit.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/sp_fwd_if.sv
`default_nettype none
// ============================================================================
//  Module      : sp_fwd_if
//  Description : Bundle of request, commit and forwarding signals for the
//                stack-pointer forwarding unit.
//                master : pipeline side; drives en, src_valid, src_sp,
//                         commit_valid, commit_op, commit_value, req
//                slave  : sp_fwd_unit; drives sp_out, sp_out_valid,
//                         sp_src_sel, arch_sp, ovf, unf
//  Revision    : 1.0  initial release
// ============================================================================
interface sp_fwd_if #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned NUM_SRC = 2
);
    localparam int unsigned SEL_W = $clog2(NUM_SRC + 1);

    logic                        en;
    logic [NUM_SRC-1:0]          src_valid;
    logic [NUM_SRC*DATA_W-1:0]   src_sp;
    logic                        commit_valid;
    logic [1:0]                  commit_op;
    logic [DATA_W-1:0]           commit_value;
    logic                        req;
    logic [DATA_W-1:0]           sp_out;
    logic                        sp_out_valid;
    logic [SEL_W-1:0]            sp_src_sel;
    logic [DATA_W-1:0]           arch_sp;
    logic                        ovf;
    logic                        unf;

    modport master (
        output en, src_valid, src_sp, commit_valid, commit_op, commit_value, req,
        input  sp_out, sp_out_valid, sp_src_sel, arch_sp, ovf, unf
    );

    modport slave (
        input  en, src_valid, src_sp, commit_valid, commit_op, commit_value, req,
        output sp_out, sp_out_valid, sp_src_sel, arch_sp, ovf, unf
    );
endinterface
`default_nettype wire

// File: rtl/sp_fwd_unit.sv
`default_nettype none
// ============================================================================
//  Module      : sp_fwd_unit
//  Description : Stack-pointer tracking and forwarding. Holds the
//                architectural SP (updated by push/pop/load commits), answers
//                SP requests one cycle later with the youngest in-flight value
//                or the (bypassed) architectural value, and keeps sticky
//                overflow/underflow flags.
//  Ports       : clk  - clock, rising edge
//                rst  - synchronous active-high reset
//                bus  - sp_fwd_if.slave (request, commit, forwarding, status)
//  Revision    : 1.0  initial release
// ============================================================================
module sp_fwd_unit #(
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       NUM_SRC  = 2,
    parameter logic [DATA_W-1:0] SP_RESET = 32'h0000_0FFE,
    parameter logic [DATA_W-1:0] SP_LIMIT = 32'h0000_0800,
    parameter int unsigned       STEP     = 2
) (
    input  logic    clk,
    input  logic    rst,
    sp_fwd_if.slave bus
);
    localparam int unsigned c_SEL_W   = $clog2(NUM_SRC + 1);
    localparam logic [1:0]  c_OP_PUSH = 2'b01;
    localparam logic [1:0]  c_OP_POP  = 2'b10;
    localparam logic [1:0]  c_OP_LOAD = 2'b11;

    logic [DATA_W-1:0]  r_arch_sp;
    logic [DATA_W-1:0]  r_sp_out;
    logic               r_sp_out_valid;
    logic [c_SEL_W-1:0] r_sp_src_sel;
    logic               r_ovf;
    logic               r_unf;

    logic [DATA_W:0]    w_push_cand;
    logic [DATA_W:0]    w_pop_cand;
    logic               w_push_blk;
    logic               w_pop_blk;
    logic [DATA_W-1:0]  w_arch_nxt;
    logic               w_ovf_set;
    logic               w_unf_set;
    logic [DATA_W-1:0]  w_fwd_sp;
    logic [c_SEL_W-1:0] w_fwd_sel;

    // One extra bit catches wrap-around: the MSB is the borrow/carry.
    assign w_push_cand = {1'b0, r_arch_sp} - (DATA_W+1)'(STEP);
    assign w_pop_cand  = {1'b0, r_arch_sp} + (DATA_W+1)'(STEP);
    assign w_push_blk  = w_push_cand[DATA_W] | (w_push_cand[DATA_W-1:0] < SP_LIMIT);
    assign w_pop_blk   = w_pop_cand[DATA_W]  | (w_pop_cand[DATA_W-1:0]  > SP_RESET);

    always_comb begin
        w_arch_nxt = r_arch_sp;
        w_ovf_set  = 1'b0;
        w_unf_set  = 1'b0;
        if (bus.commit_valid) begin
            case (bus.commit_op)
                c_OP_PUSH: begin
                    if (w_push_blk) w_ovf_set  = 1'b1;
                    else            w_arch_nxt = w_push_cand[DATA_W-1:0];
                end
                c_OP_POP: begin
                    if (w_pop_blk)  w_unf_set  = 1'b1;
                    else            w_arch_nxt = w_pop_cand[DATA_W-1:0];
                end
                c_OP_LOAD: w_arch_nxt = bus.commit_value;
                default:   ;
            endcase
        end
    end

    // Descending scan so the lowest (youngest) valid index is the last
    // assignment and wins. With no valid source the post-commit architectural
    // value is forwarded, which bypasses a same-cycle commit.
    always_comb begin
        w_fwd_sp  = w_arch_nxt;
        w_fwd_sel = c_SEL_W'(NUM_SRC);
        for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
            if (bus.src_valid[i]) begin
                w_fwd_sp  = bus.src_sp[i*DATA_W +: DATA_W];
                w_fwd_sel = c_SEL_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_arch_sp      <= SP_RESET;
            r_sp_out       <= SP_RESET;
            r_sp_out_valid <= 1'b0;
            r_sp_src_sel   <= c_SEL_W'(NUM_SRC);
            r_ovf          <= 1'b0;
            r_unf          <= 1'b0;
        end else begin
            r_arch_sp <= w_arch_nxt;
            if (w_ovf_set) r_ovf <= 1'b1;
            if (w_unf_set) r_unf <= 1'b1;
            if (bus.en && bus.req) begin
                r_sp_out       <= w_fwd_sp;
                r_sp_src_sel   <= w_fwd_sel;
                r_sp_out_valid <= 1'b1;
            end else begin
                r_sp_out_valid <= 1'b0;
            end
        end
    end

    assign bus.sp_out       = r_sp_out;
    assign bus.sp_out_valid = r_sp_out_valid;
    assign bus.sp_src_sel   = r_sp_src_sel;
    assign bus.arch_sp      = r_arch_sp;
    assign bus.ovf          = r_ovf;
    assign bus.unf          = r_unf;
endmodule
`default_nettype wire

// File: tb/tb_sp_fwd_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sp_fwd_unit
//  Description : Self-checking bench for sp_fwd_unit: directed scenarios with
//                literal expectations, then randomized traffic compared every
//                cycle against a behavioural model of the SP rules.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sp_fwd_unit;
    localparam int    DW    = 32;
    localparam int    NS    = 2;
    localparam longint RSTV = 64'h0FFE;
    localparam longint LIM  = 64'h0800;
    localparam longint STP  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sp_fwd_if #(.DATA_W(DW), .NUM_SRC(NS)) bus ();

    sp_fwd_unit #(
        .DATA_W(DW), .NUM_SRC(NS), .SP_RESET(32'h0000_0FFE),
        .SP_LIMIT(32'h0000_0800), .STEP(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int     total = 0;
    int     bad   = 0;
    bit     chk_en = 1'b0;

    // model state
    longint m_arch, m_out;
    int     m_sel;
    bit     m_valid, m_ovf, m_unf;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Applies the SP rules to the inputs present at the edge just taken.
    task automatic model_step();
        longint a;
        bit     found;
        if (rst) begin
            m_arch = RSTV; m_out = RSTV; m_sel = NS;
            m_valid = 0; m_ovf = 0; m_unf = 0;
            return;
        end
        a = m_arch;
        if (bus.commit_valid) begin
            case (bus.commit_op)
                2'b01: if (a - STP < LIM)  m_ovf = 1; else a = a - STP;
                2'b10: if (a + STP > RSTV) m_unf = 1; else a = a + STP;
                2'b11: a = longint'(bus.commit_value);
                default: ;
            endcase
        end
        if (bus.en && bus.req) begin
            m_valid = 1;
            found   = 0;
            for (int k = 0; k < NS; k++) begin
                if (!found && bus.src_valid[k]) begin
                    found = 1;
                    m_sel = k;
                    m_out = longint'(bus.src_sp[k*DW +: DW]);
                end
            end
            if (!found) begin
                m_sel = NS;
                m_out = a;
            end
        end else begin
            m_valid = 0;
        end
        m_arch = a;
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("arch_sp",      longint'(bus.arch_sp),      m_arch);
            check("sp_out_valid", longint'(bus.sp_out_valid), longint'(m_valid));
            check("sp_out",       longint'(bus.sp_out),       m_out);
            check("sp_src_sel",   longint'(bus.sp_src_sel),   longint'(m_sel));
            check("ovf",          longint'(bus.ovf),          longint'(m_ovf));
            check("unf",          longint'(bus.unf),          longint'(m_unf));
        end
    end

    task automatic cyc(input bit r, input bit e, input bit q, input bit cv,
                       input logic [1:0] op, input logic [31:0] val,
                       input logic [1:0] sv, input logic [31:0] s0,
                       input logic [31:0] s1);
        rst              = r;
        bus.en           = e;
        bus.req          = q;
        bus.commit_valid = cv;
        bus.commit_op    = op;
        bus.commit_value = val;
        bus.src_valid    = sv;
        bus.src_sp       = {s1, s0};
        @(posedge clk);
        #1;
        model_step();
        chk_en = 1'b1;
    endtask

    function automatic logic [31:0] rand_load();
        case ($urandom % 4)
            0: return $urandom;
            1: return 32'h0800 + ($urandom % 8);
            2: return 32'h0FF8 + ($urandom % 8);
            default: return $urandom % 4;
        endcase
    endfunction

    initial begin
        logic [1:0] op;
        // T1: reset state, then plain request
        cyc(1, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0);
        cyc(1, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0);
        check("rst_arch", longint'(bus.arch_sp), 64'h0FFE);
        check("rst_valid", longint'(bus.sp_out_valid), 0);
        check("rst_sel", longint'(bus.sp_src_sel), 2);
        check("rst_flags", longint'({bus.ovf, bus.unf}), 0);
        cyc(0, 1, 1, 0, 2'b00, 0, 2'b00, 0, 0);
        check("t1_out", longint'(bus.sp_out), 64'h0FFE);
        check("t1_valid", longint'(bus.sp_out_valid), 1);
        check("t1_sel", longint'(bus.sp_src_sel), 2);
        // T2: push with same-cycle request bypasses
        cyc(0, 1, 1, 1, 2'b01, 0, 2'b00, 0, 0);
        check("t2_arch", longint'(bus.arch_sp), 64'h0FFC);
        check("t2_bypass", longint'(bus.sp_out), 64'h0FFC);
        cyc(0, 1, 0, 1, 2'b01, 0, 2'b00, 0, 0);
        check("t2_arch2", longint'(bus.arch_sp), 64'h0FFA);
        check("t2_novalid", longint'(bus.sp_out_valid), 0);
        // T3: source priority
        cyc(0, 1, 1, 0, 2'b00, 0, 2'b11, 32'h0F00, 32'h0E00);
        check("t3_out0", longint'(bus.sp_out), 64'h0F00);
        check("t3_sel0", longint'(bus.sp_src_sel), 0);
        cyc(0, 1, 1, 0, 2'b00, 0, 2'b10, 32'h0F00, 32'h0E00);
        check("t3_out1", longint'(bus.sp_out), 64'h0E00);
        check("t3_sel1", longint'(bus.sp_src_sel), 1);
        // T4: overflow at the limit, sticky across a pop
        cyc(0, 1, 0, 1, 2'b11, 32'h0800, 2'b00, 0, 0);
        cyc(0, 1, 0, 1, 2'b01, 0, 2'b00, 0, 0);
        check("t4_arch", longint'(bus.arch_sp), 64'h0800);
        check("t4_ovf", longint'(bus.ovf), 1);
        cyc(0, 1, 0, 1, 2'b10, 0, 2'b00, 0, 0);
        check("t4_pop", longint'(bus.arch_sp), 64'h0802);
        check("t4_ovf_sticky", longint'(bus.ovf), 1);
        // T5: underflow at the top, reset overrides commit and request
        cyc(1, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0);
        cyc(0, 1, 0, 1, 2'b10, 0, 2'b00, 0, 0);
        check("t5_arch", longint'(bus.arch_sp), 64'h0FFE);
        check("t5_unf", longint'(bus.unf), 1);
        cyc(1, 1, 1, 1, 2'b01, 0, 2'b00, 0, 0);
        check("t5_rst_arch", longint'(bus.arch_sp), 64'h0FFE);
        check("t5_rst_flags", longint'({bus.ovf, bus.unf}), 0);
        check("t5_rst_valid", longint'(bus.sp_out_valid), 0);
        // T6: stalled request path, commits still advance
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 1, 1, 2'b01, 0, 2'b00, 0, 0);
            check("t6_valid", longint'(bus.sp_out_valid), 0);
            check("t6_hold", longint'(bus.sp_out), 64'h0FFE);
            check("t6_arch", longint'(bus.arch_sp), 64'h0FFE - 2 * (i + 1));
        end
        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            case ($urandom % 8)
                0:       op = 2'b00;
                1, 2, 3: op = 2'b01;
                4, 5, 6: op = 2'b10;
                default: op = 2'b11;
            endcase
            cyc(($urandom % 100) == 0, ($urandom % 5) != 0, ($urandom % 5) < 3,
                ($urandom % 5) < 3, op, rand_load(),
                (($urandom % 2) == 0) ? 2'b00 : 2'($urandom % 4),
                $urandom, $urandom);
        end
        @(negedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
